// File: rtl/pixel_burst_addr_gen.sv
// pixel_burst_addr_gen
// Turns each group of PIXELS_PER_GROUP output pixels into one or two AXI
// write-address commands. A 4-stage pipeline computes the start byte address.
// Groups that cross a 4 KB page are split into two commands.
// Commands are queued in a small FWFT command FIFO whose head drives the AW
// channel directly from flops.
module pixel_burst_addr_gen #(
  parameter int ADDR_W           = 32,
  parameter int COORD_W          = 16,
  parameter int STRIDE_W         = 14,
  parameter int PIXELS_PER_GROUP = 8,
  parameter int CMD_DEPTH        = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          pixel_mode_i,
  input  logic [ADDR_W-1:0]   dst_addr_i,
  input  logic [STRIDE_W-1:0] pixel_stride_i,
  input  logic                pixel_valid_i,
  output logic                pixel_ready_o,
  input  logic [COORD_W-1:0]  pixel_x_i,
  input  logic [COORD_W-1:0]  pixel_y_i,
  output logic                addr_valid_o,
  input  logic                addr_ready_i,
  output logic [ADDR_W-1:0]   addr_o,
  output logic [3:0]          addr_len_o,
  output logic [1:0]          addr_first_byte_o,
  output logic                addr_last_o,
  output logic                busy_o
);

  localparam int CNT_W  = $clog2(PIXELS_PER_GROUP);
  localparam int PTR_W  = $clog2(CMD_DEPTH);
  localparam int FCNT_W = PTR_W + 1;
  localparam int XOFF_W = COORD_W + 2;
  localparam int YOFF_W = COORD_W + STRIDE_W;
  localparam int YLO_W  = COORD_W / 2;
  localparam int YHI_W  = COORD_W - YLO_W;
  localparam int PLO_W  = YLO_W + STRIDE_W;
  localparam int PHI_W  = YHI_W + STRIDE_W;
  localparam int PAGE_W = ADDR_W - 12;
  localparam int CMD_W  = ADDR_W + 4 + 2 + 1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_MUL   = 3'd1;
  localparam logic [2:0] ST_SUM1  = 3'd2;
  localparam logic [2:0] ST_SUM2  = 3'd3;
  localparam logic [2:0] ST_EMIT  = 3'd4;
  localparam logic [2:0] ST_EMIT2 = 3'd5;

  logic [2:0]          state_r;
  logic [2:0]          state_nxt_s;
  logic [CNT_W-1:0]    grp_cnt_r;
  logic [COORD_W-1:0]  x_r;
  logic [COORD_W-1:0]  y_r;
  logic [XOFF_W-1:0]   x_off_r;
  logic [PLO_W-1:0]    pp_lo_r;
  logic [PHI_W-1:0]    pp_hi_r;
  logic [YOFF_W-1:0]   y_off_r;
  logic [ADDR_W-1:0]   hoff_r;
  logic [ADDR_W-1:0]   start_r;

  logic                pixel_ready_s;
  logic                pix_hs_s;
  logic                grp_start_s;
  logic [2:0]          bpp_s;
  logic [5:0]          group_bytes_s;
  logic [6:0]          total_s;
  logic [10:0]         line_end_s;
  logic [10:0]         b1_s;
  logic                split_s;
  logic [PAGE_W-1:0]   page_nxt_s;

  logic                push_s;
  logic                pop_s;
  logic [ADDR_W-1:0]   cmd_addr_s;
  logic [3:0]          cmd_len_s;
  logic [1:0]          cmd_fb_s;
  logic                cmd_last_s;
  logic [CMD_W-1:0]    push_data_s;

  logic [CMD_W-1:0]    fifo_mem_r [CMD_DEPTH];
  logic [FCNT_W-1:0]   fifo_cnt_r;
  logic [FCNT_W-1:0]   fifo_cnt_nxt_s;
  logic [FCNT_W-1:0]   fifo_free_s;
  logic [PTR_W-1:0]    wr_idx_s;
  logic                fifo_valid_r;

  // Handshake and group-start decode; a new group waits for the pipeline and two free slots
  always_comb begin
    fifo_free_s   = FCNT_W'(CMD_DEPTH) - fifo_cnt_r;
    pixel_ready_s = (grp_cnt_r != {CNT_W{1'b0}}) |
                    ((state_r == ST_IDLE) & (fifo_free_s >= FCNT_W'(2)));
    pix_hs_s      = pixel_valid_i & pixel_ready_s;
    grp_start_s   = pix_hs_s & (grp_cnt_r == {CNT_W{1'b0}});
  end

  // Burst sizing from the computed start address
  always_comb begin
    bpp_s         = {1'b0, pixel_mode_i} + 3'd1;
    group_bytes_s = 6'(PIXELS_PER_GROUP) * {3'b000, bpp_s};
    total_s       = (7'(start_r[1:0]) + 7'(group_bytes_s) + 7'd3) >> 2;
    line_end_s    = {1'b0, start_r[11:2]} + {4'b0000, total_s};
    split_s       = (line_end_s > 11'd1024);
    b1_s          = 11'd1024 - {1'b0, start_r[11:2]};
    page_nxt_s    = start_r[ADDR_W-1:12] + PAGE_W'(1);
  end

  // FSM next-state: fixed 4-cycle address pipeline, optional second emit for page split
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grp_start_s) begin
          state_nxt_s = ST_MUL;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_MUL:  state_nxt_s = ST_SUM1;
      ST_SUM1: state_nxt_s = ST_SUM2;
      ST_SUM2: state_nxt_s = ST_EMIT;
      ST_EMIT: begin
        if (split_s) begin
          state_nxt_s = ST_EMIT2;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_EMIT2: state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // Command construction for the FIFO push in EMIT/EMIT2
  always_comb begin
    push_s     = 1'b0;
    cmd_addr_s = {ADDR_W{1'b0}};
    cmd_len_s  = 4'd0;
    cmd_fb_s   = 2'd0;
    cmd_last_s = 1'b0;
    case (state_r)
      ST_EMIT: begin
        push_s     = 1'b1;
        cmd_addr_s = {start_r[ADDR_W-1:2], 2'b00};
        cmd_fb_s   = start_r[1:0];
        if (split_s) begin
          cmd_len_s  = 4'(b1_s - 11'd1);
          cmd_last_s = 1'b0;
        end else begin
          cmd_len_s  = 4'(total_s - 7'd1);
          cmd_last_s = 1'b1;
        end
      end
      ST_EMIT2: begin
        push_s     = 1'b1;
        cmd_addr_s = {page_nxt_s, 12'h000};
        cmd_len_s  = 4'({4'b0000, total_s} - b1_s - 11'd1);
        cmd_fb_s   = 2'd0;
        cmd_last_s = 1'b1;
      end
      default: begin
        push_s = 1'b0;
      end
    endcase
    push_data_s = {cmd_addr_s, cmd_len_s, cmd_fb_s, cmd_last_s};
  end

  // FSM state and group counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      grp_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (pix_hs_s) begin
        grp_cnt_r <= grp_cnt_r + CNT_W'(1);
      end
    end
  end

  // Address pipeline: capture, x*bpp and split y*stride, partial sums, final start
  always_ff @(posedge clk) begin
    if (rst) begin
      x_r     <= {COORD_W{1'b0}};
      y_r     <= {COORD_W{1'b0}};
      x_off_r <= {XOFF_W{1'b0}};
      pp_lo_r <= {PLO_W{1'b0}};
      pp_hi_r <= {PHI_W{1'b0}};
      y_off_r <= {YOFF_W{1'b0}};
      hoff_r  <= {ADDR_W{1'b0}};
      start_r <= {ADDR_W{1'b0}};
    end else begin
      if ((state_r == ST_IDLE) && grp_start_s) begin
        x_r <= pixel_x_i;
        y_r <= pixel_y_i;
      end
      if (state_r == ST_MUL) begin
        x_off_r <= XOFF_W'(x_r) * XOFF_W'(bpp_s);
        pp_lo_r <= PLO_W'(y_r[YLO_W-1:0]) * PLO_W'(pixel_stride_i);
        pp_hi_r <= PHI_W'(y_r[COORD_W-1:YLO_W]) * PHI_W'(pixel_stride_i);
      end
      if (state_r == ST_SUM1) begin
        hoff_r  <= dst_addr_i + ADDR_W'(x_off_r);
        y_off_r <= (YOFF_W'(pp_hi_r) << YLO_W) + YOFF_W'(pp_lo_r);
      end
      if (state_r == ST_SUM2) begin
        start_r <= hoff_r + ADDR_W'(y_off_r);
      end
    end
  end

  // FIFO occupancy and write slot; entry 0 is always the head
  always_comb begin
    pop_s = fifo_valid_r & addr_ready_i;
    case ({push_s, pop_s})
      2'b10:   fifo_cnt_nxt_s = fifo_cnt_r + FCNT_W'(1);
      2'b01:   fifo_cnt_nxt_s = fifo_cnt_r - FCNT_W'(1);
      default: fifo_cnt_nxt_s = fifo_cnt_r;
    endcase
    if (pop_s) begin
      wr_idx_s = PTR_W'(fifo_cnt_r - FCNT_W'(1));
    end else begin
      wr_idx_s = PTR_W'(fifo_cnt_r);
    end
  end

  // Shift-register command FIFO so the AW outputs come straight from flops
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_cnt_r   <= {FCNT_W{1'b0}};
      fifo_valid_r <= 1'b0;
      for (int i = 0; i < CMD_DEPTH; i++) begin
        fifo_mem_r[i] <= {CMD_W{1'b0}};
      end
    end else begin
      fifo_cnt_r   <= fifo_cnt_nxt_s;
      fifo_valid_r <= (fifo_cnt_nxt_s != {FCNT_W{1'b0}});
      for (int i = 0; i < CMD_DEPTH - 1; i++) begin
        if (pop_s) begin
          fifo_mem_r[i] <= fifo_mem_r[i+1];
        end
      end
      if (push_s) begin
        fifo_mem_r[wr_idx_s] <= push_data_s;
      end
    end
  end

  assign pixel_ready_o = pixel_ready_s;
  assign addr_valid_o  = fifo_valid_r;
  assign {addr_o, addr_len_o, addr_first_byte_o, addr_last_o} = fifo_mem_r[0];
  assign busy_o        = (state_r != ST_IDLE) | fifo_valid_r;

endmodule

// File: tb/tb_pixel_burst_addr_gen.sv
// Testbench for pixel_burst_addr_gen: table of single-group vectors with
// hand-computed commands, plus sequences for backpressure, reset and split.
module tb_pixel_burst_addr_gen;

  localparam int PPG = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  pixel_mode_i;
  logic [31:0] dst_addr_i;
  logic [13:0] pixel_stride_i;
  logic        pixel_valid_i;
  logic        pixel_ready_o;
  logic [15:0] pixel_x_i;
  logic [15:0] pixel_y_i;
  logic        addr_valid_o;
  logic        addr_ready_i;
  logic [31:0] addr_o;
  logic [3:0]  addr_len_o;
  logic [1:0]  addr_first_byte_o;
  logic        addr_last_o;
  logic        busy_o;

  always #5 clk = ~clk;

  pixel_burst_addr_gen #(
    .ADDR_W(32), .COORD_W(16), .STRIDE_W(14), .PIXELS_PER_GROUP(PPG), .CMD_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .pixel_mode_i(pixel_mode_i), .dst_addr_i(dst_addr_i),
    .pixel_stride_i(pixel_stride_i), .pixel_valid_i(pixel_valid_i),
    .pixel_ready_o(pixel_ready_o), .pixel_x_i(pixel_x_i), .pixel_y_i(pixel_y_i),
    .addr_valid_o(addr_valid_o), .addr_ready_i(addr_ready_i), .addr_o(addr_o),
    .addr_len_o(addr_len_o), .addr_first_byte_o(addr_first_byte_o),
    .addr_last_o(addr_last_o), .busy_o(busy_o)
  );

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] dst;
    logic [13:0] stride;
    logic [15:0] x;
    logic [15:0] y;
    int          ncmd;
    logic [31:0] a0;
    logic [3:0]  l0;
    logic [1:0]  f0;
    logic        t0;
    logic [31:0] a1;
    logic [3:0]  l1;
  } vec_t;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          last_hs_cyc = 0;
  int          first_hs_cyc = 0;
  int          rise_cyc = -1;
  logic        pix_hs = 1'b0;
  logic        prev_valid = 1'b0;
  logic [38:0] sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic exp_cmd(input logic [31:0] a, input logic [3:0] l, input logic [1:0] f, input logic t);
    sb.push_back({a, l, f, t});
  endtask

  // One clock: sample at negedge (handshakes of the coming edge), then step past posedge
  task automatic tick();
    logic [38:0] e;
    @(negedge clk);
    pix_hs = pixel_valid_i & pixel_ready_o;
    if (pix_hs) last_hs_cyc = cyc;
    if (!rst) begin
      if (addr_valid_o && !prev_valid) rise_cyc = cyc;
      if (addr_valid_o && addr_ready_i) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL cmd_unexpected: got addr 0x%0h len %0d, expected no command", addr_o, addr_len_o);
        end else begin
          e = sb.pop_front();
          check("cmd", 64'({addr_o, addr_len_o, addr_first_byte_o, addr_last_o}), 64'(e));
        end
      end
    end
    prev_valid = addr_valid_o;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send_group(input logic [15:0] x0, input logic [15:0] y0);
    int n;
    for (int i = 0; i < PPG; i++) begin
      pixel_valid_i = 1'b1;
      pixel_x_i     = x0 + 16'(i);
      pixel_y_i     = y0;
      tick();
      if (i > 0) check("mid_pixel_ready", 64'(pix_hs), 64'd1);
      n = 0;
      while (!pix_hs && n < 200) begin
        tick();
        n++;
      end
      if (!pix_hs) begin
        tests++;
        fails++;
        $display("FAIL pixel_timeout: pixel %0d not accepted in 200 cycles, expected acceptance", i);
        pixel_valid_i = 1'b0;
        return;
      end
      if (i == 0) first_hs_cyc = last_hs_cyc;
    end
    pixel_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    tick();
    while ((busy_o || addr_valid_o || sb.size() != 0) && n < 300) begin
      tick();
      n++;
    end
    if (busy_o || addr_valid_o || sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL idle_timeout: busy=%0d valid=%0d pending=%0d, expected all zero", busy_o, addr_valid_o, sb.size());
    end
  endtask

  task automatic stall_check();
    for (int k = 0; k < 3; k++) begin
      tick();
      check("group_start_stall", 64'(pix_hs), 64'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    int   n;
    vecs[0] = '{2'd1, 32'h1000_0000, 14'd1280,   16'd8,     16'd2,     1, 32'h1000_0A10, 4'd3, 2'd0, 1'b1, 32'h0,         4'd0};
    vecs[1] = '{2'd3, 32'h2000_0FF0, 14'd64,     16'd0,     16'd0,     2, 32'h2000_0FF0, 4'd3, 2'd0, 1'b0, 32'h2000_1000, 4'd3};
    vecs[2] = '{2'd2, 32'h3000_0000, 14'd64,     16'd1,     16'd0,     1, 32'h3000_0000, 4'd6, 2'd3, 1'b1, 32'h0,         4'd0};
    vecs[3] = '{2'd0, 32'h3000_0000, 14'd64,     16'd5,     16'd0,     1, 32'h3000_0004, 4'd2, 2'd1, 1'b1, 32'h0,         4'd0};
    vecs[4] = '{2'd2, 32'h4000_0FF0, 14'd0,      16'd2,     16'd0,     2, 32'h4000_0FF4, 4'd2, 2'd2, 1'b0, 32'h4000_1000, 4'd3};
    vecs[5] = '{2'd1, 32'h0000_0100, 14'h3FFF,   16'd0,     16'hFFFF,  1, 32'h3FFE_C100, 4'd4, 2'd1, 1'b1, 32'h0,         4'd0};
    vecs[6] = '{2'd3, 32'hFFFF_FFF8, 14'd0,      16'd1,     16'd0,     2, 32'hFFFF_FFFC, 4'd0, 2'd0, 1'b0, 32'h0000_0000, 4'd6};
    vecs[7] = '{2'd3, 32'h5000_0FE0, 14'd0,      16'd0,     16'd0,     1, 32'h5000_0FE0, 4'd7, 2'd0, 1'b1, 32'h0,         4'd0};

    rst = 1'b1; pixel_valid_i = 1'b0; addr_ready_i = 1'b0;
    pixel_mode_i = 2'd1; dst_addr_i = 32'h0; pixel_stride_i = 14'd0;
    pixel_x_i = 16'd0; pixel_y_i = 16'd0;
    repeat (3) tick();
    check("reset_addr_valid", 64'(addr_valid_o), 64'd0);
    check("reset_busy", 64'(busy_o), 64'd0);
    check("reset_pixel_ready", 64'(pixel_ready_o), 64'd1);
    rst = 1'b0;
    tick();

    // Single-group vectors with the AW channel always ready
    addr_ready_i = 1'b1;
    for (int v = 0; v < 8; v++) begin
      pixel_mode_i = vecs[v].mode; dst_addr_i = vecs[v].dst; pixel_stride_i = vecs[v].stride;
      exp_cmd(vecs[v].a0, vecs[v].l0, vecs[v].f0, vecs[v].t0);
      if (vecs[v].ncmd == 2) exp_cmd(vecs[v].a1, vecs[v].l1, 2'd0, 1'b1);
      rise_cyc = -1;
      send_group(vecs[v].x, vecs[v].y);
      wait_idle();
      check("valid_latency", 64'(rise_cyc - first_hs_cyc), 64'd5);
    end

    // Backpressure: three queued commands block the next group start only
    pixel_mode_i = 2'd1; dst_addr_i = 32'h1000_0000; pixel_stride_i = 14'd1280;
    addr_ready_i = 1'b0;
    exp_cmd(32'h1000_0000, 4'd3, 2'd0, 1'b1); send_group(16'd0, 16'd0);
    exp_cmd(32'h1000_0010, 4'd3, 2'd0, 1'b1); send_group(16'd8, 16'd0);
    exp_cmd(32'h1000_0020, 4'd3, 2'd0, 1'b1); send_group(16'd16, 16'd0);
    exp_cmd(32'h1000_0030, 4'd3, 2'd0, 1'b1);
    pixel_valid_i = 1'b1; pixel_x_i = 16'd24; pixel_y_i = 16'd0;
    stall_check();
    check("bp_head_valid", 64'(addr_valid_o), 64'd1);
    addr_ready_i = 1'b1;
    send_group(16'd24, 16'd0);
    wait_idle();

    // Reset while the third group sits in SUM1 with two commands queued
    addr_ready_i = 1'b0;
    send_group(16'd0, 16'd1);
    send_group(16'd8, 16'd1);
    pixel_valid_i = 1'b1; pixel_x_i = 16'd16; pixel_y_i = 16'd1;
    n = 0;
    tick();
    while (!pix_hs && n < 50) begin
      tick();
      n++;
    end
    check("rst_seq_first_pixel", 64'(pix_hs), 64'd1);
    pixel_valid_i = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("midrst_addr_valid", 64'(addr_valid_o), 64'd0);
    check("midrst_busy", 64'(busy_o), 64'd0);
    check("midrst_pixel_ready", 64'(pixel_ready_o), 64'd1);
    rst = 1'b0;
    sb.delete();
    addr_ready_i = 1'b1;
    exp_cmd(32'h1000_0510, 4'd3, 2'd0, 1'b1);
    send_group(16'd8, 16'd1);
    wait_idle();

    // Split group accepted with exactly two free slots, filling the FIFO
    pixel_mode_i = 2'd3; dst_addr_i = 32'h2000_0FC0; pixel_stride_i = 14'd0;
    addr_ready_i = 1'b0;
    exp_cmd(32'h2000_0FC0, 4'd7, 2'd0, 1'b1); send_group(16'd0, 16'd0);
    exp_cmd(32'h2000_0FE0, 4'd7, 2'd0, 1'b1); send_group(16'd8, 16'd0);
    exp_cmd(32'h2000_0FF0, 4'd3, 2'd0, 1'b0);
    exp_cmd(32'h2000_1000, 4'd3, 2'd0, 1'b1); send_group(16'd12, 16'd0);
    exp_cmd(32'h2000_1000, 4'd7, 2'd0, 1'b1);
    pixel_valid_i = 1'b1; pixel_x_i = 16'd16; pixel_y_i = 16'd0;
    stall_check();
    check("full_head_valid", 64'(addr_valid_o), 64'd1);
    addr_ready_i = 1'b1;
    send_group(16'd16, 16'd0);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
